mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, width of all address ports.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_if_req  input  1  fetch read request; held with stable address until o_if_gnt.
REQ-005 SHALL have port: i_if_addr  input  ADDR_W  fetch byte address, word-aligned.
REQ-006 SHALL have port: o_if_gnt  output  1  fetch request accepted by memory this cycle.
REQ-007 SHALL have port: o_if_rvalid / o_if_rdata  output  1 / 32  fetch response strobe and instruction word.
REQ-008 SHALL have port: i_d_req, i_d_we  input  1 each  data request; write when i_d_we=1; held stable until o_d_gnt.
REQ-009 SHALL have port: i_d_addr / i_d_wdata / i_d_wmask  input  ADDR_W / 32 / 32  data address, pre-shifted store data, byte-lane bit mask.
REQ-010 SHALL have port: o_d_gnt, o_d_rvalid / o_d_rdata  output  1, 1 / 32  data accept, response strobe (loads and stores), load data.
REQ-011 SHALL have port: o_m_req, o_m_we / o_m_addr / o_m_wdata / o_m_wmask  output  1, 1 / ADDR_W / 32 / 32  shared memory request.
REQ-012 SHALL have port: i_m_gnt, i_m_rvalid / i_m_rdata  input  1, 1 / 32  memory accept, response strobe (one per accepted request, reads and writes), read data.
REQ-013 SHALL have port: o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, REQ (owner locked, awaiting i_m_gnt), WAIT (accepted, awaiting i_m_rvalid); owner register holds IF or D.
REQ-015 SHALL in IDLE select owner combinationally among asserted requests (tie rule per REQ-027/028) and drive o_m_req plus that owner's fields in the same cycle.
REQ-016 SHALL assert o_X_gnt = o_m_req && i_m_gnt for the current owner only; never both grants in one cycle.
REQ-017 SHALL transition IDLE->WAIT on request accepted same cycle, IDLE->REQ on request not accepted, REQ->WAIT on i_m_gnt, WAIT->IDLE on i_m_rvalid.
REQ-018 SHALL in REQ keep the locked owner and its fields on o_m_* even if the other requester asserts; no re-arbitration until grant.
REQ-019 SHALL hold o_m_req=0 in WAIT; at most one outstanding memory transaction.
REQ-020 SHALL route i_m_rvalid in WAIT to the owner's rvalid in the same cycle (zero-cycle response latency); o_X_rdata = i_m_rdata when o_X_rvalid else 0.
REQ-021 SHALL ignore i_m_rvalid in IDLE or REQ (no rvalid output pulse, no state change).
REQ-022 SHALL accept a new request no earlier than the cycle after WAIT->IDLE; minimum 2 cycles per transaction.
REQ-023 SHALL drive o_m_we=0, o_m_wdata=0, o_m_wmask=0 for fetch transactions and whenever o_m_req=0; o_m_addr=0 when o_m_req=0.

Reset
REQ-024 SHALL on i_rst_n=0 force state IDLE, owner IF, last-grant IF, all outputs 0, immediately and independent of i_clk.
REQ-025 SHALL abandon any in-flight transaction on reset mid-operation; a later i_m_rvalid for it is ignored per REQ-021.
REQ-026 SHALL resume arbitration on the first rising edge after reset release.

Configuration
REQ-027 SHALL, with MEM_ARB_RR_EN defined, resolve simultaneous IDLE requests round-robin: grant the requester not granted last; last-grant register updated on each grant; reset value IF, so first tie goes to D.
REQ-028 SHALL, without MEM_ARB_RR_EN, give D fixed priority on ties; last-grant register absent; fetch may starve under continuous data requests.

Verification
REQ-029 SHALL cover: fetch only, addr 0x100, i_m_gnt same cycle, i_m_rvalid next cycle with 0x00000013 -> o_if_gnt cycle 0, o_if_rvalid cycle 1 with rdata 0x00000013, o_busy high cycle 1 only.
REQ-030 SHALL cover: both requests in IDLE (IF 0x0, D load 0x2000) -> D granted first in both configurations; with MEM_ARB_RR_EN a second tie grants IF, without it grants D.
REQ-031 SHALL cover: IF request, i_m_gnt low 3 cycles, D asserts cycle 1 -> o_m_addr stays 0x0 until grant, D served only after IF's rvalid.
REQ-032 SHALL cover: store addr 0x3004, wdata 0x0000AB00, wmask 0x0000FF00 -> o_m_we=1 with those values, o_d_rvalid pulses on write ack, o_d_rdata=0.
REQ-033 SHALL cover: reset asserted in WAIT, then i_m_rvalid after release -> all outputs 0 during reset, no rvalid output pulse afterwards.
REQ-034 SHALL cover: i_m_rvalid in IDLE with no request -> no output change.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch "IF" and data "D")
// for a single shared memory port. It allows at most one outstanding memory
// transaction at a time.
//
// Optional build macro: MEM_ARB_RR_EN
//   defined   -> ties in IDLE go round-robin. A last-grant register is kept,
//                and the first tie after reset goes to D.
//   undefined -> D has fixed priority on ties.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_if_req/i_if_addr       fetch request; o_if_gnt accept; o_if_rvalid/o_if_rdata response
//   i_d_req/i_d_we/i_d_addr  data request (load/store)
//   i_d_wdata/i_d_wmask      store data and byte-lane bit mask
//   o_d_gnt, o_d_rvalid/o_d_rdata  data accept, response strobe, load data
//   o_m_*                    shared memory request (req, we, addr, wdata, wmask)
//   i_m_gnt, i_m_rvalid/i_m_rdata  memory accept, response strobe, read data
//   o_busy                   high whenever the FSM is not IDLE
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [31:0]       i_d_wmask,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_wdata,
  output logic [31:0]       o_m_wmask,
  input  logic              i_m_gnt,
  input  logic              i_m_rvalid,
  input  logic [31:0]       i_m_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t r_state, w_state_nxt;
  owner_t r_owner, w_sel, w_own;
  logic   w_m_req, w_gnt, w_rsp;

`ifdef MEM_ARB_RR_EN
  owner_t r_last;
`endif

  // Arbitration among the current requests; the result is only used in IDLE.
  always_comb begin
    w_sel = OWN_IF;
    if (i_d_req && i_if_req) begin
`ifdef MEM_ARB_RR_EN
      w_sel = (r_last == OWN_IF) ? OWN_D : OWN_IF;
`else
      w_sel = OWN_D;
`endif
    end else if (i_d_req) begin
      w_sel = OWN_D;
    end
  end

  // Reset gates the request so that every output is zero while reset is held,
  // even if a requester keeps its request asserted.
  always_comb begin
    w_own   = (r_state == S_IDLE) ? w_sel : r_owner;
    w_m_req = i_rst_n && (((r_state == S_IDLE) && (i_if_req || i_d_req)) ||
                          (r_state == S_REQ));
    w_gnt   = w_m_req && i_m_gnt;
    w_rsp   = (r_state == S_WAIT) && i_m_rvalid;
  end

  always_comb begin
    o_m_req     = w_m_req;
    o_m_we      = 1'b0;
    o_m_addr    = '0;
    o_m_wdata   = '0;
    o_m_wmask   = '0;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    o_if_rvalid = 1'b0;
    o_d_rvalid  = 1'b0;
    o_if_rdata  = '0;
    o_d_rdata   = '0;
    o_busy      = (r_state != S_IDLE);
    if (w_m_req) begin
      if (w_own == OWN_D) begin
        o_m_we    = i_d_we;
        o_m_addr  = i_d_addr;
        o_m_wdata = i_d_wdata;
        o_m_wmask = i_d_wmask;
        o_d_gnt   = i_m_gnt;
      end else begin
        o_m_addr  = i_if_addr;
        o_if_gnt  = i_m_gnt;
      end
    end
    if (w_rsp) begin
      if (r_owner == OWN_D) begin
        o_d_rvalid = 1'b1;
        o_d_rdata  = i_m_rdata;
      end else begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = i_m_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_m_req) w_state_nxt = w_gnt ? S_WAIT : S_REQ;
      S_REQ:   if (w_gnt)   w_state_nxt = S_WAIT;
      S_WAIT:  if (w_rsp)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_owner <= OWN_IF;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_m_req) r_owner <= w_sel;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_last <= OWN_IF;
    else if (w_gnt) r_last <= w_own;
  end
`endif

endmodule
